hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RV32I core. It drives the `stall` input of the PC register and the hold/flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves three hazard classes:
- load-use hazards, with a one-bubble insertion;
- taken branch/jump redirects, by flushing the wrong-path instructions;
- variable-latency data-memory accesses, with a full-pipeline freeze, a watchdog timeout and a stall-cycle performance counter.

## Interface
Parameters:
- `MAX_WAIT`, default 16: maximum consecutive memory-wait cycles before the timeout trips. Legal range is 2..255.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  5 each  source register indices of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_memread`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  the EX instruction is a taken branch or jump; NPC is redirected.
- `mem_req`  in  1  the MEM-stage instruction is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `stall`  out  1  hold the PC; connects to PC `stall`.
- `stall_ifid`, `stall_idex`, `stall_exmem`  out  1 each  hold the corresponding pipeline register.
- `flush_ifid`, `flush_idex`  out  1 each  load a NOP into the corresponding pipeline register on the next edge.
- `mem_timeout`  out  1  sticky error: memory wait exceeded `MAX_WAIT`.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `stall`=1.

## Operation
Conditions, evaluated combinationally each cycle:
- LU (load-use) = `ex_memread` & (`ex_rd`≠0) & ((`id_rs1_used` & `id_rs1`==`ex_rd`) | (`id_rs2_used` & `id_rs2`==`ex_rd`)).
- MW (memory wait) = `mem_req` & !`mem_ready`.

States are RUN, WAIT and ERR.

Output priority, highest first:
1. ERR: `stall` and all `stall_*` are 1; both flushes are 0.
2. MW (in RUN or WAIT): `stall` and all `stall_*` are 1; both flushes are 0. A pending redirect or LU is held because EX is frozen, and it re-evaluates once the freeze ends.
3. `ex_redirect`: `flush_ifid`=1 and `flush_idex`=1; all stalls 0. LU is ignored because the ID instruction is wrong-path.
4. LU: `stall`=1, `stall_ifid`=1, `flush_idex`=1; `stall_idex`=0 and `stall_exmem`=0. This inserts one bubble.
5. Otherwise all control outputs are 0.

State transitions, on the rising edge:
- RUN → WAIT when MW; `wait_cnt` goes to 1.
- WAIT stays in WAIT when MW and `wait_cnt` < `MAX_WAIT`−1; `wait_cnt` increments.
- WAIT → ERR when MW and `wait_cnt` == `MAX_WAIT`−1; `mem_timeout` is set to 1.
- WAIT → RUN when !MW, including `mem_req` dropping; `wait_cnt` goes to 0.
- ERR is terminal until `rst`.

`stall_cycles` increments on each edge where `stall`=1 and it holds at 2^`CNT_W`−1.

## Timing
- All stall and flush outputs are combinational from the current inputs and state. They must settle before the edge, because the PC and pipeline registers sample them on the same rising edge.
- A load-use costs exactly one bubble cycle. In the next cycle the load has moved to MEM, so LU is false.
- Memory-wait latency:
  - An access with `mem_ready`=1 in its first cycle costs 0 stall cycles.
  - An access that waits N cycles costs N stall cycles, for N ≤ `MAX_WAIT`−1.
  - MW persisting for `MAX_WAIT` cycles enters ERR at the `MAX_WAIT`-th edge.
- Reset values: state RUN, `wait_cnt` 0, `mem_timeout` 0, `stall_cycles` 0.
- While `rst` is high, every stall and flush output is forced to 0.
- Reset asserted mid-wait or in ERR returns the block immediately to RUN with cleared counters.
- Simultaneous events:
  - `ex_redirect` and LU together: flush only, no stall.
  - MW with `ex_redirect`: freeze only. The redirect takes effect in the first cycle after MW clears.

## Test plan
- Load-use: `ex_memread`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 for one cycle. Required: `stall`=1, `stall_ifid`=1, `flush_idex`=1; the PC holds, for example at 0x0000_0010; `stall_cycles` goes 0→1. With `ex_rd`=0, or with `id_rs2_used`=0, all outputs stay 0.
- Redirect overrides LU: drive the LU condition together with `ex_redirect`=1. Required: `flush_ifid`=1, `flush_idex`=1, `stall`=0; `stall_cycles` is unchanged.
- Memory wait: `mem_req`=1 with `mem_ready`=0 for 3 cycles, then `mem_ready`=1. Required:
  - all four stalls are 1 for exactly 3 cycles;
  - state follows RUN→WAIT→WAIT→WAIT→RUN;
  - `stall_cycles` increases by 3;
  - `mem_timeout`=0.
- Timeout (`MAX_WAIT`=4): `mem_req`=1 and `mem_ready`=0 held indefinitely. Required: `mem_timeout` rises at the 4th edge and stays 1; the stalls stay 1 even after `mem_ready`=1. Asserting `rst` asynchronously, mid-cycle, clears `mem_timeout`, the state and the counter immediately, and the stalls drop to 0.
- MW with pending redirect: `ex_redirect`=1 during a 2-cycle wait. Required: no flush during the wait; `flush_ifid` and `flush_idex` pulse for 1 cycle right after `mem_ready`.
- Counter saturation (`CNT_W`=4): more than 15 stall cycles. Required: `stall_cycles` holds at 4'hF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and stall controller for the five-stage RV32I core.
//
// Resolves three hazard classes:
//   - load-use: inserts one bubble (hold PC and IF/ID, NOP into ID/EX)
//   - taken branch/jump redirect: flushes IF/ID and ID/EX
//   - variable-latency data memory: freezes the whole pipeline, with a
//     watchdog that enters a terminal error state after MAX_WAIT cycles
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   id_rs1/id_rs2, *_used         source registers of the ID instruction
//   ex_rd, ex_memread             destination / load flag of the EX instruction
//   ex_redirect                   EX instruction redirects the PC
//   mem_req, mem_ready            MEM-stage access handshake
//   stall, stall_ifid/idex/exmem  hold PC / pipeline registers (combinational)
//   flush_ifid, flush_idex        load NOP into pipeline registers (combinational)
//   mem_timeout                   sticky watchdog error
//   stall_cycles                  saturating count of cycles with stall=1
module hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_exmem,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t             state_q, state_d;
    logic [7:0]         wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic lu, mw;

    assign lu = ex_memread && (ex_rd != 5'd0) &&
                ((id_rs1_used && (id_rs1 == ex_rd)) ||
                 (id_rs2_used && (id_rs2 == ex_rd)));
    assign mw = mem_req && !mem_ready;

    // Control outputs. A freeze outranks redirect and load-use: EX is held,
    // so those conditions simply re-evaluate once the freeze lifts.
    always_comb begin
        stall       = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        if (rst) begin
            // all controls forced low while reset is asserted
        end else if (state_q == S_ERR || mw) begin
            stall       = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
        end else if (ex_redirect) begin
            // ID holds a wrong-path instruction, so any load-use is moot
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (lu) begin
            stall      = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
        end
    end

    // Next-state logic for the memory-wait watchdog.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            S_RUN: begin
                if (mw) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            S_WAIT: begin
                if (!mw) begin
                    state_d    = S_RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d   = S_ERR;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_ERR: begin
                // terminal until reset
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk, rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_rs1_used, id_rs2_used, ex_memread, ex_redirect, mem_req, mem_ready;
    logic       stall, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex;
    logic       mem_timeout;
    logic [3:0] stall_cycles;

    hazard_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .stall(stall), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // control vector order: {stall, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex}
    localparam logic [5:0] Z   = 6'b000000;
    localparam logic [5:0] STL = 6'b111100;
    localparam logic [5:0] LUO = 6'b110001;
    localparam logic [5:0] FLO = 6'b000011;

    typedef struct packed {
        logic [5:0] ctl;
        logic       to;
        logic [3:0] cnt;
        int         id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   vec_id = 0;
    bit   stim_done = 1'b0;

    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic mr, input logic rdr, input logic rq,
                        input logic ry, input logic r,
                        input logic [5:0] ectl, input logic eto, input logic [3:0] ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd = rd; ex_memread = mr; ex_redirect = rdr;
        mem_req = rq; mem_ready = ry; rst = r;
        e.ctl = ectl; e.to = eto; e.cnt = ecnt; e.id = vec_id;
        vec_id++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] ectl, input logic eto, input logic [3:0] ecnt);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ectl, eto, ecnt);
    endtask

    task automatic mem(input logic rq, input logic ry, input logic rdr,
                       input logic [5:0] ectl, input logic eto, input logic [3:0] ecnt);
        step(0, 0, 0, 0, 0, 0, rdr, rq, ry, 0, ectl, eto, ecnt);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response;
    // sample it mid-cycle and compare against the oldest pending expectation.
    initial begin
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                act = {stall, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex};
                n_cmp++;
                if (act !== e.ctl) begin
                    n_err++;
                    $display("FAIL ctl vec=%0d got=%b exp=%b", e.id, act, e.ctl);
                end
                n_cmp++;
                if (mem_timeout !== e.to) begin
                    n_err++;
                    $display("FAIL timeout vec=%0d got=%b exp=%b", e.id, mem_timeout, e.to);
                end
                n_cmp++;
                if (stall_cycles !== e.cnt) begin
                    n_err++;
                    $display("FAIL stall_cycles vec=%0d got=%0d exp=%0d", e.id, stall_cycles, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_memread = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;

        // reset forces controls low even with a memory wait pending
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, Z, 0, 0);
        idle(Z, 0, 0);

        // load-use via rs2, then the bubble is counted
        step(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, LUO, 0, 0);
        idle(Z, 0, 1);
        // ex_rd = x0 never hazards
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, Z, 0, 1);
        // rs2 not read
        step(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, Z, 0, 1);
        // load-use via rs1
        step(7, 0, 1, 0, 7, 1, 0, 0, 0, 0, LUO, 0, 1);
        // redirect overrides load-use: flush only, counter unchanged next cycle
        step(0, 5, 0, 1, 5, 1, 1, 0, 0, 0, FLO, 0, 2);
        idle(Z, 0, 2);
        // not a load: no hazard
        step(0, 5, 0, 1, 5, 0, 0, 0, 0, 0, Z, 0, 2);

        // 3-cycle memory wait
        mem(1, 0, 0, STL, 0, 2);
        mem(1, 0, 0, STL, 0, 3);
        mem(1, 0, 0, STL, 0, 4);
        mem(1, 1, 0, Z, 0, 5);
        idle(Z, 0, 5);

        // 2-cycle wait with a pending redirect: flush right after ready
        mem(1, 0, 1, STL, 0, 5);
        mem(1, 0, 1, STL, 0, 6);
        mem(1, 1, 1, FLO, 0, 7);
        idle(Z, 0, 7);

        // zero-wait access
        mem(1, 1, 0, Z, 0, 7);

        // timeout at the 4th edge, sticky even after ready
        mem(1, 0, 0, STL, 0, 7);
        mem(1, 0, 0, STL, 0, 8);
        mem(1, 0, 0, STL, 0, 9);
        mem(1, 0, 0, STL, 0, 10);
        mem(1, 0, 0, STL, 1, 11);
        mem(1, 1, 0, STL, 1, 12);
        mem(0, 0, 1, STL, 1, 13);
        // asynchronous reset mid-cycle clears everything at once
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, Z, 0, 0);
        idle(Z, 0, 0);

        // saturation: 20 load-use stalls on a 4-bit counter
        for (int i = 0; i < 20; i++)
            step(0, 3, 0, 1, 3, 1, 0, 0, 0, 0, LUO, 0, (i > 15) ? 4'hF : 4'(i));
        idle(Z, 0, 4'hF);
        mem(1, 0, 0, STL, 0, 4'hF);
        mem(1, 1, 0, Z, 0, 4'hF);

        // drain the scoreboard, bounded
        for (int k = 0; k < 5 && exp_q.size() != 0; k++)
            @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d", exp_q.size());
        end
        stim_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global watchdog so the run always terminates
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog timeout");
            $fatal(1, "watchdog");
        end
    end

endmodule
